fwd_hazard_ctrl: RTL and testbench

Parametrised successor to the EX-stage forwarding unit. It adds a load-use hazard detector with a bubble-count state machine, so the same block serves single- and two-cycle data memories. It sits between ID/EX control and the pipeline registers. It drives the ALU operand mux selects, the IF/ID hold, the ID/EX bubble insert, and a saturating stall-cycle counter for the per-core performance registers.

---
 rtl/fwd_hazard_ctrl.sv | 129 ++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
// EX-stage forwarding unit with load-use hazard detection and a bubble-count FSM.
// Supports single-cycle (LOAD_BUBBLES=1) and two-stage (LOAD_BUBBLES=2) data memories.
module fwd_hazard_ctrl #(
   parameter int REG_AW       = 5,
   parameter int LOAD_BUBBLES = 1,
   parameter int STALL_CNT_W  = 16
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   flush_i,
   input  logic [REG_AW-1:0]      id_rs_i,
   input  logic [REG_AW-1:0]      id_rt_i,
   input  logic                   id_rs_used_i,
   input  logic                   id_rt_used_i,
   input  logic [REG_AW-1:0]      ex_rs_i,
   input  logic [REG_AW-1:0]      ex_rt_i,
   input  logic [REG_AW-1:0]      ex_rd_i,
   input  logic                   ex_memrd_i,
   input  logic [REG_AW-1:0]      mem_rd_i,
   input  logic                   mem_wb_i,
   input  logic                   mem_memrd_i,
   input  logic [REG_AW-1:0]      wb_rd_i,
   input  logic                   wb_wb_i,
   output logic [1:0]             forwarda_o,
   output logic [1:0]             forwardb_o,
   output logic                   stall_o,
   output logic                   bubble_o,
   output logic [STALL_CNT_W-1:0] stall_cnt_o
);

   typedef enum logic {IDLE, STALL} stateT;

   localparam logic TWO_CYC = (LOAD_BUBBLES == 2);

   stateT                  r_state;
   logic [1:0]             r_cnt;
   logic [STALL_CNT_W-1:0] r_stallCnt;

   logic w_memFwdOk;
   logic w_wbFwdOk;
   logic w_useEx;
   logic w_useMem;
   logic w_h1;
   logic w_h2;
   logic w_stall;

   // With a two-stage memory the MEM-stage value of a load is not yet available
   assign w_memFwdOk = mem_wb_i && (mem_rd_i != '0) && !(TWO_CYC && mem_memrd_i);
   assign w_wbFwdOk  = wb_wb_i && (wb_rd_i != '0);

   assign w_useEx  = (ex_rd_i != '0) &&
                     ((id_rs_used_i && (ex_rd_i == id_rs_i)) ||
                      (id_rt_used_i && (ex_rd_i == id_rt_i)));
   assign w_useMem = (mem_rd_i != '0) &&
                     ((id_rs_used_i && (mem_rd_i == id_rs_i)) ||
                      (id_rt_used_i && (mem_rd_i == id_rt_i)));

   assign w_h1 = ex_memrd_i && w_useEx;
   assign w_h2 = TWO_CYC && mem_memrd_i && mem_wb_i && w_useMem;

   always_comb begin
      forwarda_o = 2'b00;
      forwardb_o = 2'b00;
      if (w_memFwdOk && (mem_rd_i == ex_rs_i)) begin
         forwarda_o = 2'b10;
      end else if (w_wbFwdOk && (wb_rd_i == ex_rs_i)) begin
         forwarda_o = 2'b01;
      end
      if (w_memFwdOk && (mem_rd_i == ex_rt_i)) begin
         forwardb_o = 2'b10;
      end else if (w_wbFwdOk && (wb_rd_i == ex_rt_i)) begin
         forwardb_o = 2'b01;
      end
   end

   always_comb begin
      w_stall = 1'b0;
      case (r_state)
         IDLE:    w_stall = !flush_i && (w_h1 || w_h2);
         STALL:   w_stall = !flush_i;
         default: w_stall = 1'b0;
      endcase
   end

   assign stall_o     = w_stall;
   assign bubble_o    = w_stall;
   assign stall_cnt_o = r_stallCnt;

   // Extra bubbles after the first are counted down in STALL; hazards are ignored there
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_cnt   <= 2'd0;
      end else begin
         case (r_state)
            IDLE: begin
               if (!flush_i && w_h1 && TWO_CYC) begin
                  r_state <= STALL;
                  r_cnt   <= 2'(LOAD_BUBBLES - 1);
               end
            end
            STALL: begin
               if (flush_i) begin
                  r_state <= IDLE;
                  r_cnt   <= 2'd0;
               end else begin
                  r_cnt <= r_cnt - 2'd1;
                  if (r_cnt == 2'd1) begin
                     r_state <= IDLE;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= 2'd0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_stallCnt <= '0;
      end else if (w_stall && (r_stallCnt != '1)) begin
         r_stallCnt <= r_stallCnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Bench for fwd_hazard_ctrl: three instances (1 bubble, 2 bubbles, 2 bubbles with a 2-bit counter)
// share one stimulus; table vectors, hand sequences and a randomized reference-model run.
module tb_fwd_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       flush;
   logic [4:0] idRs, idRt, exRs, exRt, exRd, memRd, wbRd;
   logic       idRsUsed, idRtUsed, exMemrd, memWb, memMemrd, wbWb;

   logic [1:0]  fa [3];
   logic [1:0]  fb [3];
   logic        st [3];
   logic        bu [3];
   logic [15:0] cnt0, cnt1;
   logic [1:0]  cnt2;

   int checks = 0;
   int errors = 0;

   int lbOf  [3] = '{1, 2, 2};
   int maxOf [3] = '{65535, 65535, 3};
   int pending [3];
   int modelCnt [3];

   typedef struct {
      logic       memWb;
      logic [4:0] memRd;
      logic       memMemrd;
      logic       wbWb;
      logic [4:0] wbRd;
      logic [4:0] exRs;
      logic [4:0] exRt;
      logic [1:0] a1, b1, a2, b2;
   } vecT;

   vecT vecs [8];

   always #5 clk = ~clk;

   fwd_hazard_ctrl #(.REG_AW(5), .LOAD_BUBBLES(1), .STALL_CNT_W(16)) dut0 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .id_rs_i(idRs), .id_rt_i(idRt), .id_rs_used_i(idRsUsed), .id_rt_used_i(idRtUsed),
      .ex_rs_i(exRs), .ex_rt_i(exRt), .ex_rd_i(exRd), .ex_memrd_i(exMemrd),
      .mem_rd_i(memRd), .mem_wb_i(memWb), .mem_memrd_i(memMemrd),
      .wb_rd_i(wbRd), .wb_wb_i(wbWb),
      .forwarda_o(fa[0]), .forwardb_o(fb[0]), .stall_o(st[0]), .bubble_o(bu[0]),
      .stall_cnt_o(cnt0));

   fwd_hazard_ctrl #(.REG_AW(5), .LOAD_BUBBLES(2), .STALL_CNT_W(16)) dut1 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .id_rs_i(idRs), .id_rt_i(idRt), .id_rs_used_i(idRsUsed), .id_rt_used_i(idRtUsed),
      .ex_rs_i(exRs), .ex_rt_i(exRt), .ex_rd_i(exRd), .ex_memrd_i(exMemrd),
      .mem_rd_i(memRd), .mem_wb_i(memWb), .mem_memrd_i(memMemrd),
      .wb_rd_i(wbRd), .wb_wb_i(wbWb),
      .forwarda_o(fa[1]), .forwardb_o(fb[1]), .stall_o(st[1]), .bubble_o(bu[1]),
      .stall_cnt_o(cnt1));

   fwd_hazard_ctrl #(.REG_AW(5), .LOAD_BUBBLES(2), .STALL_CNT_W(2)) dut2 (
      .clk_i(clk), .rst_i(rst), .flush_i(flush),
      .id_rs_i(idRs), .id_rt_i(idRt), .id_rs_used_i(idRsUsed), .id_rt_used_i(idRtUsed),
      .ex_rs_i(exRs), .ex_rt_i(exRt), .ex_rd_i(exRd), .ex_memrd_i(exMemrd),
      .mem_rd_i(memRd), .mem_wb_i(memWb), .mem_memrd_i(memMemrd),
      .wb_rd_i(wbRd), .wb_wb_i(wbWb),
      .forwarda_o(fa[2]), .forwardb_o(fb[2]), .stall_o(st[2]), .bubble_o(bu[2]),
      .stall_cnt_o(cnt2));

   function automatic int getCnt(input int i);
      if (i == 0) return int'(cnt0);
      if (i == 1) return int'(cnt1);
      return int'(cnt2);
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic clearInputs();
      flush = 0; idRs = 0; idRt = 0; idRsUsed = 0; idRtUsed = 0;
      exRs = 0; exRt = 0; exRd = 0; exMemrd = 0;
      memRd = 0; memWb = 0; memMemrd = 0; wbRd = 0; wbWb = 0;
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyReset();
      rst = 1'b1;
      clearInputs();
      nextCycle();
      rst = 1'b0;
   endtask

   // Reference rules written directly from the behavioural description
   function automatic logic [1:0] refFwd(input int lb, input logic [4:0] src);
      if (memWb && memRd != 0 && memRd == src && !(lb == 2 && memMemrd)) return 2'b10;
      if (wbWb && wbRd != 0 && wbRd == src) return 2'b01;
      return 2'b00;
   endfunction

   function automatic bit usedByIdt(input logic [4:0] r);
      return (r != 0) && ((idRsUsed && r == idRs) || (idRtUsed && r == idRt));
   endfunction

   function automatic bit refStall(input int i);
      bit h1, h2;
      h1 = exMemrd && usedByIdt(exRd);
      h2 = (lbOf[i] == 2) && memMemrd && memWb && usedByIdt(memRd);
      if (flush) return 0;
      if (pending[i] > 0) return 1;
      return h1 || h2;
   endfunction

   task automatic applyStimulus(input int cycles);
      bit expSt [3];
      bit h1;
      for (int c = 0; c < cycles; c++) begin
         flush    = ($urandom_range(0, 9) == 0);
         idRs     = 5'($urandom_range(0, 3));
         idRt     = 5'($urandom_range(0, 3));
         idRsUsed = 1'($urandom_range(0, 1));
         idRtUsed = 1'($urandom_range(0, 1));
         exRs     = 5'($urandom_range(0, 3));
         exRt     = 5'($urandom_range(0, 3));
         exRd     = 5'($urandom_range(0, 3));
         exMemrd  = 1'($urandom_range(0, 1));
         memRd    = 5'($urandom_range(0, 3));
         memWb    = 1'($urandom_range(0, 1));
         memMemrd = 1'($urandom_range(0, 1));
         wbRd     = 5'($urandom_range(0, 3));
         wbWb     = 1'($urandom_range(0, 1));
         #3;
         h1 = exMemrd && usedByIdt(exRd);
         for (int i = 0; i < 3; i++) begin
            expSt[i] = refStall(i);
            checkOutput($sformatf("rand%0d fwdA inst%0d", c, i), fa[i], refFwd(lbOf[i], exRs));
            checkOutput($sformatf("rand%0d fwdB inst%0d", c, i), fb[i], refFwd(lbOf[i], exRt));
            checkOutput($sformatf("rand%0d stall inst%0d", c, i), st[i], expSt[i]);
            checkOutput($sformatf("rand%0d bubble inst%0d", c, i), bu[i], expSt[i]);
         end
         @(posedge clk);
         for (int i = 0; i < 3; i++) begin
            if (flush) pending[i] = 0;
            else if (pending[i] > 0) pending[i]--;
            else if (h1) pending[i] = lbOf[i] - 1;
            if (expSt[i] && modelCnt[i] < maxOf[i]) modelCnt[i]++;
         end
         #1;
         for (int i = 0; i < 3; i++)
            checkOutput($sformatf("rand%0d count inst%0d", c, i), getCnt(i), modelCnt[i]);
      end
   endtask

   initial begin
      vecs[0] = '{1'b1, 5'd3, 1'b0, 1'b1, 5'd3, 5'd3, 5'd4, 2'b10, 2'b00, 2'b10, 2'b00};
      vecs[1] = '{1'b1, 5'd0, 1'b0, 1'b1, 5'd3, 5'd0, 5'd4, 2'b00, 2'b00, 2'b00, 2'b00};
      vecs[2] = '{1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 5'd5, 5'd5, 2'b10, 2'b10, 2'b00, 2'b00};
      vecs[3] = '{1'b1, 5'd5, 1'b1, 1'b1, 5'd5, 5'd5, 5'd5, 2'b10, 2'b10, 2'b01, 2'b01};
      vecs[4] = '{1'b0, 5'd6, 1'b0, 1'b1, 5'd6, 5'd6, 5'd1, 2'b01, 2'b00, 2'b01, 2'b00};
      vecs[5] = '{1'b1, 5'd2, 1'b0, 1'b1, 5'd7, 5'd7, 5'd2, 2'b01, 2'b10, 2'b01, 2'b10};
      vecs[6] = '{1'b0, 5'd0, 1'b0, 1'b0, 5'd7, 5'd7, 5'd7, 2'b00, 2'b00, 2'b00, 2'b00};
      vecs[7] = '{1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 2'b00, 2'b00};

      rst = 1'b1;
      clearInputs();
      #2;
      for (int i = 0; i < 3; i++) begin
         checkOutput($sformatf("reset stall inst%0d", i), st[i], 0);
         checkOutput($sformatf("reset fwdA inst%0d", i), fa[i], 0);
         checkOutput($sformatf("reset count inst%0d", i), getCnt(i), 0);
      end
      nextCycle();
      rst = 1'b0;

      // Combinational forwarding table
      for (int v = 0; v < 8; v++) begin
         memWb = vecs[v].memWb; memRd = vecs[v].memRd; memMemrd = vecs[v].memMemrd;
         wbWb = vecs[v].wbWb; wbRd = vecs[v].wbRd; exRs = vecs[v].exRs; exRt = vecs[v].exRt;
         #1;
         checkOutput($sformatf("vec%0d fwdA lb1", v), fa[0], vecs[v].a1);
         checkOutput($sformatf("vec%0d fwdB lb1", v), fb[0], vecs[v].b1);
         checkOutput($sformatf("vec%0d fwdA lb2", v), fa[1], vecs[v].a2);
         checkOutput($sformatf("vec%0d fwdB lb2", v), fb[1], vecs[v].b2);
         checkOutput($sformatf("vec%0d stall lb2", v), st[1], 0);
      end

      // Load in EX used by rt in ID
      applyReset();
      exMemrd = 1; exRd = 5; idRt = 5; idRtUsed = 1;
      #1;
      checkOutput("ldEx c0 stall lb1", st[0], 1);
      checkOutput("ldEx c0 bubble lb1", bu[0], 1);
      checkOutput("ldEx c0 stall lb2", st[1], 1);
      nextCycle();
      exMemrd = 0; exRd = 0; memMemrd = 1; memWb = 1; memRd = 5; exRs = 5;
      #1;
      checkOutput("ldEx c1 stall lb1", st[0], 0);
      checkOutput("ldEx c1 stall lb2", st[1], 1);
      checkOutput("ldEx c1 count lb1", cnt0, 1);
      checkOutput("ldEx c1 fwdA lb1", fa[0], 2'b10);
      checkOutput("ldEx c1 fwdA lb2", fa[1], 2'b00);
      nextCycle();
      memMemrd = 0; memWb = 0; memRd = 0; exRs = 0;
      idRt = 0; idRtUsed = 0; wbWb = 1; wbRd = 5; exRt = 5;
      #1;
      checkOutput("ldEx c2 fwdB lb1", fb[0], 2'b01);
      checkOutput("ldEx c2 stall lb2", st[1], 0);
      checkOutput("ldEx c2 count lb1", cnt0, 1);
      checkOutput("ldEx c2 count lb2", cnt1, 2);

      // Load in MEM used by rs in ID
      applyReset();
      memMemrd = 1; memWb = 1; memRd = 7; idRs = 7; idRsUsed = 1;
      #1;
      checkOutput("ldMem c0 stall lb2", st[1], 1);
      checkOutput("ldMem c0 stall lb1", st[0], 0);
      nextCycle();
      memMemrd = 0; memWb = 0; memRd = 0;
      #1;
      checkOutput("ldMem c1 stall lb2", st[1], 0);
      checkOutput("ldMem c1 count lb2", cnt1, 1);
      checkOutput("ldMem c1 count lb1", cnt0, 0);

      // Flush cancels the second bubble
      applyReset();
      exMemrd = 1; exRd = 5; idRt = 5; idRtUsed = 1;
      #1;
      checkOutput("flush c0 stall lb2", st[1], 1);
      nextCycle();
      exMemrd = 0; exRd = 0; idRt = 0; idRtUsed = 0; flush = 1;
      #1;
      checkOutput("flush c1 stall lb2", st[1], 0);
      checkOutput("flush c1 bubble lb2", bu[1], 0);
      nextCycle();
      flush = 0;
      #1;
      checkOutput("flush c2 stall lb2", st[1], 0);
      checkOutput("flush c2 count lb2", cnt1, 1);

      // Counter saturation and asynchronous reset while in STALL
      applyReset();
      exMemrd = 1; exRd = 5; idRt = 5; idRtUsed = 1;
      for (int k = 0; k < 6; k++) begin
         #2;
         checkOutput($sformatf("sat c%0d stall w2", k), st[2], 1);
         nextCycle();
      end
      checkOutput("sat count w2", cnt2, 3);
      checkOutput("sat count w16", cnt1, 6);
      nextCycle();
      exMemrd = 0; exRd = 0; idRt = 0; idRtUsed = 0;
      #1;
      checkOutput("midStall stall w2", st[2], 1);
      rst = 1'b1;
      #1;
      checkOutput("asyncRst stall w2", st[2], 0);
      checkOutput("asyncRst count w2", cnt2, 0);
      checkOutput("asyncRst count w16", cnt1, 0);
      nextCycle();
      rst = 1'b0;

      // Randomized run against the reference model
      applyReset();
      for (int i = 0; i < 3; i++) begin
         pending[i]  = 0;
         modelCnt[i] = 0;
      end
      applyStimulus(400);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
